// File: rtl/acc_arbiter.sv
// Round-robin arbiter sharing one accelerator between NumReq requesters.
// Requests are forwarded combinationally; responses are routed back by the index bits of the ID.

module acc_arbiter_rsp_lane #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 5
) (
    input  logic                 hit_i,
    input  logic                 mst_p_valid_i,
    input  logic [DataWidth-1:0] mst_p_data0_i,
    input  logic [DataWidth-1:0] mst_p_data1_i,
    input  logic                 mst_p_dual_writeback_i,
    input  logic [IdWidth-1:0]   mst_p_id_i,
    input  logic                 mst_p_error_i,
    output logic                 rdy_o,
    output logic [DataWidth-1:0] slv_p_data0_o,
    output logic [DataWidth-1:0] slv_p_data1_o,
    output logic                 slv_p_dual_writeback_o,
    output logic [IdWidth-1:0]   slv_p_id_o,
    output logic                 slv_p_error_o,
    output logic                 slv_p_valid_o,
    input  logic                 slv_p_ready_i
);
    assign slv_p_valid_o          = hit_i & mst_p_valid_i;
    assign rdy_o                  = hit_i & slv_p_ready_i;
    assign slv_p_data0_o          = mst_p_data0_i;
    assign slv_p_data1_o          = mst_p_data1_i;
    assign slv_p_dual_writeback_o = mst_p_dual_writeback_i;
    assign slv_p_id_o             = mst_p_id_i;
    assign slv_p_error_o          = mst_p_error_i;
endmodule

module acc_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned IdWidth   = 5,
    localparam int unsigned IdxW       = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned MstIdWidth = IdWidth + IdxW
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0][AddrWidth-1:0]    slv_q_addr_i,
    input  logic [NumReq-1:0][31:0]             slv_q_data_op_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    slv_q_data_arga_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    slv_q_data_argb_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    slv_q_data_argc_i,
    input  logic [NumReq-1:0][IdWidth-1:0]      slv_q_id_i,
    input  logic [NumReq-1:0]                   slv_q_valid_i,
    output logic [NumReq-1:0]                   slv_q_ready_o,
    output logic [NumReq-1:0][DataWidth-1:0]    slv_p_data0_o,
    output logic [NumReq-1:0][DataWidth-1:0]    slv_p_data1_o,
    output logic [NumReq-1:0]                   slv_p_dual_writeback_o,
    output logic [NumReq-1:0][IdWidth-1:0]      slv_p_id_o,
    output logic [NumReq-1:0]                   slv_p_error_o,
    output logic [NumReq-1:0]                   slv_p_valid_o,
    input  logic [NumReq-1:0]                   slv_p_ready_i,
    output logic [AddrWidth-1:0]                mst_q_addr_o,
    output logic [31:0]                         mst_q_data_op_o,
    output logic [DataWidth-1:0]                mst_q_data_arga_o,
    output logic [DataWidth-1:0]                mst_q_data_argb_o,
    output logic [DataWidth-1:0]                mst_q_data_argc_o,
    output logic [MstIdWidth-1:0]               mst_q_id_o,
    output logic                                mst_q_valid_o,
    input  logic                                mst_q_ready_i,
    input  logic [DataWidth-1:0]                mst_p_data0_i,
    input  logic [DataWidth-1:0]                mst_p_data1_i,
    input  logic                                mst_p_dual_writeback_i,
    input  logic [MstIdWidth-1:0]               mst_p_id_i,
    input  logic                                mst_p_error_i,
    input  logic                                mst_p_valid_i,
    output logic                                mst_p_ready_o
);
    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [31:0]          op;
        logic [DataWidth-1:0] arga;
        logic [DataWidth-1:0] argb;
        logic [DataWidth-1:0] argc;
        logic [IdWidth-1:0]   id;
    } req_t;

    typedef enum logic {Idle, Locked} state_e;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_q, rr_d, lock_q, lock_d;
    logic [IdxW-1:0]   rr_win, cand, win;
    logic              found, any, hs;
    req_t [NumReq-1:0] req;
    req_t              sel;

    for (genvar g = 0; g < NumReq; g++) begin : g_req
        assign req[g] = '{addr: slv_q_addr_i[g], op: slv_q_data_op_i[g], arga: slv_q_data_arga_i[g],
                          argb: slv_q_data_argb_i[g], argc: slv_q_data_argc_i[g], id: slv_q_id_i[g]};
    end

    // Rotating priority search starting at rr_q; a stalled winner stays pinned while Locked.
    always_comb begin
        rr_win = rr_q;
        found  = 1'b0;
        cand   = rr_q;
        for (int o = 0; o < NumReq; o++) begin
            if (!found && slv_q_valid_i[cand]) begin
                rr_win = cand;
                found  = 1'b1;
            end
            cand = (cand == LastIdx) ? '0 : cand + IdxW'(1);
        end
        win = (state_q == Locked) ? lock_q : rr_win;
    end

    assign any = |slv_q_valid_i;
    assign hs  = any & mst_q_ready_i;
    assign sel = req[win];

    always_comb begin
        slv_q_ready_o      = '0;
        slv_q_ready_o[win] = hs;
    end

    assign mst_q_valid_o     = any;
    assign mst_q_addr_o      = sel.addr;
    assign mst_q_data_op_o   = sel.op;
    assign mst_q_data_arga_o = sel.arga;
    assign mst_q_data_argb_o = sel.argb;
    assign mst_q_data_argc_o = sel.argc;
    assign mst_q_id_o        = {win, sel.id};

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        case (state_q)
            Idle: begin
                if (any && !mst_q_ready_i) begin
                    state_d = Locked;
                    lock_d  = win;
                end
            end
            Locked: if (hs) state_d = Idle;
            default: state_d = Idle;
        endcase
        if (hs) rr_d = (win == LastIdx) ? '0 : win + IdxW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            rr_q    <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
        end
    end

    // Responses whose index names no requester match no lane and are sunk here.
    logic [IdxW-1:0]   pk;
    logic [NumReq-1:0] hit, lane_rdy;

    assign pk            = mst_p_id_i[MstIdWidth-1:IdWidth];
    assign mst_p_ready_o = (|lane_rdy) | ~(|hit);

    for (genvar g = 0; g < NumReq; g++) begin : g_lane
        assign hit[g] = (pk == IdxW'(g));
        acc_arbiter_rsp_lane #(
            .DataWidth (DataWidth),
            .IdWidth   (IdWidth)
        ) i_lane (
            .hit_i                  (hit[g]),
            .mst_p_valid_i          (mst_p_valid_i),
            .mst_p_data0_i          (mst_p_data0_i),
            .mst_p_data1_i          (mst_p_data1_i),
            .mst_p_dual_writeback_i (mst_p_dual_writeback_i),
            .mst_p_id_i             (mst_p_id_i[IdWidth-1:0]),
            .mst_p_error_i          (mst_p_error_i),
            .rdy_o                  (lane_rdy[g]),
            .slv_p_data0_o          (slv_p_data0_o[g]),
            .slv_p_data1_o          (slv_p_data1_o[g]),
            .slv_p_dual_writeback_o (slv_p_dual_writeback_o[g]),
            .slv_p_id_o             (slv_p_id_o[g]),
            .slv_p_error_o          (slv_p_error_o[g]),
            .slv_p_valid_o          (slv_p_valid_o[g]),
            .slv_p_ready_i          (slv_p_ready_i[g])
        );
    end
endmodule

// File: tb/tb_acc_arbiter.sv
// Bench for acc_arbiter with three requesters: directed scenarios then random traffic,
// checked by a queue-based scoreboard fed from a behavioural model.

module tb_acc_arbiter;
    localparam int N = 3, DW = 32, AW = 5, IW = 5, XW = 2, MW = IW + XW;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0][AW-1:0] q_addr;
    logic [N-1:0][31:0]   q_op;
    logic [N-1:0][DW-1:0] q_a, q_b, q_c, p_d0, p_d1;
    logic [N-1:0][IW-1:0] q_id, p_id;
    logic [N-1:0]         q_valid, q_ready, p_dw, p_err, p_valid, p_ready;
    logic [AW-1:0]        m_q_addr;
    logic [31:0]          m_q_op;
    logic [DW-1:0]        m_q_a, m_q_b, m_q_c, m_p_d0, m_p_d1;
    logic [MW-1:0]        m_q_id, m_p_id;
    logic                 m_q_valid, m_q_ready, m_p_dw, m_p_err, m_p_valid, m_p_ready;

    acc_arbiter #(.NumReq(N), .DataWidth(DW), .AddrWidth(AW), .IdWidth(IW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_q_addr_i(q_addr), .slv_q_data_op_i(q_op), .slv_q_data_arga_i(q_a),
        .slv_q_data_argb_i(q_b), .slv_q_data_argc_i(q_c), .slv_q_id_i(q_id),
        .slv_q_valid_i(q_valid), .slv_q_ready_o(q_ready),
        .slv_p_data0_o(p_d0), .slv_p_data1_o(p_d1), .slv_p_dual_writeback_o(p_dw),
        .slv_p_id_o(p_id), .slv_p_error_o(p_err), .slv_p_valid_o(p_valid), .slv_p_ready_i(p_ready),
        .mst_q_addr_o(m_q_addr), .mst_q_data_op_o(m_q_op), .mst_q_data_arga_o(m_q_a),
        .mst_q_data_argb_o(m_q_b), .mst_q_data_argc_o(m_q_c), .mst_q_id_o(m_q_id),
        .mst_q_valid_o(m_q_valid), .mst_q_ready_i(m_q_ready),
        .mst_p_data0_i(m_p_d0), .mst_p_data1_i(m_p_d1), .mst_p_dual_writeback_i(m_p_dw),
        .mst_p_id_i(m_p_id), .mst_p_error_i(m_p_err), .mst_p_valid_i(m_p_valid),
        .mst_p_ready_o(m_p_ready)
    );

    typedef struct {
        logic          qv;
        logic [N-1:0]  qr;
        logic [127:0]  qpay;
        logic [MW-1:0] qid;
        logic          pr;
        logic [N-1:0]  pv;
        int            k;
        logic [127:0]  ppay;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;

    // Reference model: who owns the accelerator port and where the rotation resumes.
    int   m_rr = 0, m_lock = 0;
    bit   m_locked = 0;
    logic [N-1:0] acc_q = '0;
    logic acc_p = 1'b0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mst_q_valid", 128'(m_q_valid), 128'(e.qv));
            chk("slv_q_ready", 128'(q_ready), 128'(e.qr));
            if (e.qv) begin
                chk("mst_q_id", 128'(m_q_id), 128'(e.qid));
                chk("mst_q_payload", {m_q_addr, m_q_op, m_q_a, m_q_b, m_q_c}, e.qpay);
            end
            chk("mst_p_ready", 128'(m_p_ready), 128'(e.pr));
            chk("slv_p_valid", 128'(p_valid), 128'(e.pv));
            if (e.k < N && e.pv[e.k])
                chk("slv_p_lane", 128'({p_id[e.k], p_d0[e.k], p_d1[e.k], p_dw[e.k], p_err[e.k]}), e.ppay);
        end
    end

    task automatic rand_req(int i);
        q_addr[i] = AW'($urandom);
        q_op[i]   = $urandom;
        q_a[i]    = $urandom;
        q_b[i]    = $urandom;
        q_c[i]    = $urandom;
        q_id[i]   = IW'($urandom);
    endtask

    task automatic rand_rsp(int k);
        m_p_id  = {XW'(k), IW'($urandom)};
        m_p_d0  = $urandom;
        m_p_d1  = $urandom;
        m_p_dw  = 1'($urandom);
        m_p_err = 1'($urandom);
    endtask

    task automatic idle_inputs();
        q_valid = '0; m_q_ready = 1'b0; m_p_valid = 1'b0; p_ready = '0;
        for (int i = 0; i < N; i++) rand_req(i);
        rand_rsp(0);
    endtask

    // One clock of traffic: predict this cycle's outputs, then advance the model at the edge.
    task automatic cycle();
        exp_t e;
        int   win;
        bit   any;
        any = |q_valid;
        win = m_rr;
        if (m_locked) win = m_lock;
        else begin
            for (int o = 0; o < N; o++)
                if (q_valid[(m_rr + o) % N]) begin
                    win = (m_rr + o) % N;
                    break;
                end
        end
        e.qv   = any;
        e.qr   = '0;
        if (any && m_q_ready) e.qr[win] = 1'b1;
        e.qid  = {XW'(win), q_id[win]};
        e.qpay = {q_addr[win], q_op[win], q_a[win], q_b[win], q_c[win]};
        e.k    = int'(m_p_id[MW-1:IW]);
        e.pv   = '0;
        if (e.k < N) begin
            e.pv[e.k] = m_p_valid;
            e.pr      = p_ready[e.k];
        end else e.pr = 1'b1;
        e.ppay = 128'({m_p_id[IW-1:0], m_p_d0, m_p_d1, m_p_dw, m_p_err});
        exp_q.push_back(e);
        @(posedge clk);
        acc_q = '0;
        if (any && m_q_ready) begin
            acc_q[win] = 1'b1;
            m_rr       = (win + 1) % N;
            m_locked   = 0;
        end else if (any && !m_locked) begin
            m_locked = 1;
            m_lock   = win;
        end
        acc_p = m_p_valid && e.pr;
        #1;
    endtask

    task automatic reset_pulse();
        idle_inputs();
        rst_n = 1'b0;
        m_rr = 0; m_lock = 0; m_locked = 0; acc_q = '0; acc_p = 1'b0;
        @(negedge clk);
        chk("rst_mst_q_valid", 128'(m_q_valid), 128'(0));
        chk("rst_slv_q_ready", 128'(q_ready), 128'(0));
        chk("rst_slv_p_valid", 128'(p_valid), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        @(posedge clk);
        #1 reset_pulse();

        // Two contenders with the port always ready: grants alternate.
        q_valid = 3'b011; m_q_ready = 1'b1;
        repeat (4) begin
            rand_req(0); rand_req(1);
            cycle();
        end

        // req0 stalls for three cycles while req1 arrives; req1 wins right after.
        q_valid = 3'b001; m_q_ready = 1'b0; rand_req(0);
        cycle();
        q_valid[1] = 1'b1; rand_req(1);
        cycle(); cycle();
        m_q_ready = 1'b1;
        cycle();
        rand_req(0);
        cycle();
        q_valid = '0;

        // Response to req1 held off for two cycles by its ready.
        m_p_valid = 1'b1; m_p_id = {2'd1, 5'd7}; m_p_d0 = 32'hcafe_0001; m_p_d1 = 32'hbeef_0002;
        m_p_dw = 1'b1; m_p_err = 1'b0; p_ready = 3'b101;
        cycle(); cycle();
        p_ready = 3'b010;
        cycle();

        // Index beyond the last requester is sunk.
        rand_rsp(3); p_ready = '0;
        cycle();

        // Request handshake on req0 together with a response to req1, then rotation resumes at 1.
        q_valid = 3'b001; rand_req(0); m_q_ready = 1'b1;
        rand_rsp(1); p_ready = 3'b010;
        cycle();
        q_valid = 3'b011; rand_req(0); rand_req(1); m_p_valid = 1'b0;
        cycle();

        // Lock on req1, reset mid-stall, then req0 must win first.
        q_valid = 3'b010; rand_req(1); m_q_ready = 1'b0;
        cycle(); cycle();
        reset_pulse();
        q_valid = 3'b011; rand_req(0); rand_req(1); m_q_ready = 1'b1;
        cycle();
        idle_inputs();
        cycle();

        // Random traffic; requesters and the accelerator hold an offer until it is taken.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!q_valid[i] || acc_q[i]) begin
                    q_valid[i] = 1'($urandom);
                    rand_req(i);
                end
            m_q_ready = ($urandom_range(0, 3) != 0);
            if (!m_p_valid || acc_p) begin
                m_p_valid = 1'($urandom);
                rand_rsp($urandom_range(0, 3));
            end
            p_ready = N'($urandom);
            cycle();
        end

        @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/acc_arbiter.md
ACC_ARBITER -- requirements
Module: acc_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requester ports (>=1).
REQ-002 SHALL have parameter DataWidth, default 32, operand/result width.
REQ-003 SHALL have parameter AddrWidth, default 5, accelerator address width.
REQ-004 SHALL have parameter IdWidth, default 5, requester-side ID width; IdxW = max(1, clog2(NumReq)); MstIdWidth = IdWidth+IdxW.
REQ-005 SHALL have port clk_i  in  1  clock; single clock domain.
REQ-006 SHALL have port rst_ni  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have ports slv_q_addr/data_op/data_arga/argb/argc/id  in  [NumReq] x AddrWidth/32/DataWidth x3/IdWidth  per-requester request payload.
REQ-008 SHALL have ports slv_q_valid in, slv_q_ready out  NumReq each  per-requester request handshake.
REQ-009 SHALL have ports slv_p_data0/data1/dual_writeback/id/error/valid out, slv_p_ready in  [NumReq] x DataWidth x2/1/IdWidth/1/1/1  per-requester response channel.
REQ-010 SHALL have ports mst_q_* out (mst_q_ready in)  same payload widths, id MstIdWidth  request channel to the shared accelerator.
REQ-011 SHALL have ports mst_p_* in (mst_p_ready out)  same widths, id MstIdWidth  response channel from the accelerator.

Function
REQ-012 SHALL arbitrate requests round-robin: winner = first i with slv_q_valid[i], searching from rr_ptr upward, wrapping at NumReq-1 to 0.
REQ-013 SHALL forward the winner combinationally (zero-cycle latency): mst_q_valid = OR(slv_q_valid); payload = winner payload; mst_q_id = {winner index, slv_q_id[winner]}.
REQ-014 SHALL drive slv_q_ready[winner] = mst_q_ready and slv_q_ready[j] = 0 for all j != winner.
REQ-015 SHALL implement state machine IDLE/LOCKED: IDLE->LOCKED when mst_q_valid && !mst_q_ready, recording winner in lock_idx; LOCKED->IDLE on mst_q_valid && mst_q_ready.
REQ-016 SHALL, in LOCKED, select lock_idx regardless of other requesters so master payload stays stable until handshake.
REQ-017 SHALL update rr_ptr = (winner+1) mod NumReq only on a completed Q handshake; otherwise rr_ptr holds.
REQ-018 SHALL route responses by mst_p_id[MstIdWidth-1:IdWidth] = k: slv_p_valid[k] = mst_p_valid, mst_p_ready = slv_p_ready[k], slv_p_id[k] = mst_p_id[IdWidth-1:0], data/dual_writeback/error passed through; slv_p_valid[j!=k] = 0.
REQ-019 SHALL, when k >= NumReq, assert mst_p_ready = 1, suppress all slv_p_valid, and drop the response.
REQ-020 SHALL allow Q and P channels to handshake independently in the same cycle.
REQ-021 SHALL, with NumReq = 1, pass all signals through with index bit 0 prepended to mst_q_id.
REQ-022 SHALL never make mst_q_valid depend on mst_q_ready, nor slv_p_valid on slv_p_ready.

Reset
REQ-023 SHALL on rst_ni low asynchronously set state = IDLE, rr_ptr = 0, lock_idx = 0.
REQ-024 SHALL, with all inputs inactive during reset, drive mst_q_valid = 0, slv_q_ready = 0, slv_p_valid = 0.
REQ-025 SHALL, on reset asserted mid-transaction while LOCKED, discard the lock; next arbitration after release starts from index 0.

Verification
REQ-026 SHALL cover: NumReq=2, both valid every cycle, mst_q_ready=1 -> grants alternate 0,1,0,1; mst_q_id MSB alternates.
REQ-027 SHALL cover: req0 valid, mst_q_ready=0 for 3 cycles, req1 raises valid in cycle 1 -> master payload/id stay req0's for all 3 cycles; req1 granted cycle after req0 handshake.
REQ-028 SHALL cover: mst_p_valid with mst_p_id = {1, 5'd7}, slv_p_ready[1]=0 for 2 cycles -> slv_p_valid[1]=1, slv_p_id[1]=7, mst_p_ready=0 until slv_p_ready[1]=1.
REQ-029 SHALL cover: NumReq=3, mst_p_id index = 3 -> mst_p_ready=1, no slv_p_valid asserted.
REQ-030 SHALL cover: rst_ni pulsed low while LOCKED on req1 -> after release, req0 and req1 valid -> req0 granted first.
REQ-031 SHALL cover: simultaneous Q handshake (req0) and P response to req1 in one cycle -> both complete, rr_ptr = 1.
